// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: address/instruction widths, opcode field,
// halt opcode, the fetch-to-decode word and the fetch halt states.
package pipe_pkg;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;

   localparam logic [3:0] OPC_HLT = 4'hF;

   // One fetched instruction together with the address it came from
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_word_t;

   typedef enum logic [1:0] {
      HS_RUN,
      HS_DRAIN,
      HS_HALTED
   } halt_state_t;

   function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
      return word[OPC_MSB:OPC_LSB] == OPC_HLT;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory read port plus the decode-facing
// instruction stream and the redirect/stall controls.
//   master : fetch side (drives memory request and instruction stream)
//   slave  : environment side (memory, decode, execute)
interface fetch_unit_if;
   import pipe_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               halted;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      input  imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      output imem_rdata, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {instr, pc} words while decode stalls.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   flush      : empty the buffer (wins over push/pop)
//   count      : number of valid entries, 0..2
//   head       : oldest entry (zero after reset)
module fetch_skid_buf
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  fetch_word_t push_data,
   input  logic        pop,
   input  logic        flush,
   output logic [1:0]  count,
   output fetch_word_t head
);

   fetch_word_t entry_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            entry_q[wr_ptr_q] <= push_data;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;
   assign head  = entry_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-based memory requests,
// skid buffering and redirect flush. A response arriving with an empty
// buffer is forwarded straight to decode, giving 1-cycle fetch latency.
// Optional halt behaviour is built when FETCH_HALT_EN is defined;
// otherwise halted is tied low and HLT words pass through as data.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (imem_req/addr/rdata, stall, redirect,
//              redirect_pc, instr, instr_pc, instr_valid, halted)
module fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] req_pc_q;
   logic            inflight_q;
   logic [1:0]      count;
   fetch_word_t     head;
   fetch_word_t     push_data;
   logic            issue_stop;
   logic            discard;
   logic            resp_live;
   logic            bypass;
   logic            pop;
   logic            buf_pop;
   logic            push;
   logic            issue;
   logic [2:0]      occupancy;

   // In-flight response counts as the buffer tail for valid and credit
   assign resp_live = inflight_q && !discard;
   assign bypass    = (count == 2'd0) && resp_live;

   assign bus.instr_valid = (count != 2'd0) || resp_live;
   assign bus.instr       = bypass ? bus.imem_rdata : head.instr;
   assign bus.instr_pc    = bypass ? req_pc_q       : head.pc;

   assign pop     = bus.instr_valid && !bus.stall && !bus.redirect;
   assign buf_pop = pop && !bypass;
   assign push    = resp_live && !bus.redirect && !(pop && bypass);

   // Credit: never let buffered + outstanding words exceed two
   assign occupancy = 3'(count) + 3'(resp_live) - 3'(pop);
   assign issue     = !rst && !bus.redirect && !issue_stop && (occupancy < 3'd2);

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc_q;

   assign push_data = '{instr: bus.imem_rdata, pc: req_pc_q};

   // PC and outstanding-request tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
         end else if (issue) begin
            pc_q     <= pc_q + PC_W'(1);
            req_pc_q <= pc_q;
         end
      end
   end

   fetch_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (buf_pop),
      .flush     (bus.redirect),
      .count     (count),
      .head      (head)
   );

`ifdef FETCH_HALT_EN
   halt_state_t state_q;
   halt_state_t state_d;
   logic        hlt_arrive;

   assign hlt_arrive = resp_live && !bus.redirect && is_hlt(bus.imem_rdata);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HS_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // HLT forwarded and accepted in its arrival cycle skips DRAIN;
   // in DRAIN the HLT is the last buffered entry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HS_RUN: begin
            if (hlt_arrive) begin
               state_d = (pop && bypass) ? HS_HALTED : HS_DRAIN;
            end
         end
         HS_DRAIN: begin
            if (bus.redirect) begin
               state_d = HS_RUN;
            end else if (buf_pop && (count == 2'd1)) begin
               state_d = HS_HALTED;
            end
         end
         HS_HALTED: state_d = HS_HALTED;
         default:   state_d = HS_RUN;
      endcase
   end

   assign issue_stop = (state_q != HS_RUN);
   assign bus.halted = (state_q == HS_HALTED);
`else
   assign issue_stop = 1'b0;
   assign bus.halted = 1'b0;
`endif

   // Once fetch stops, any response still returning is younger than HLT
   assign discard = issue_stop;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected {instr, pc}.
module tb_fetch_unit;
   import pipe_pkg::*;

   logic clk;
   logic rst;
   bit   hlt_at3;
   int   checks;
   int   failures;
   int   req_cnt;

   fetch_word_t exp_q[$];
   fetch_word_t wexp_q[$];

   fetch_unit_if bus();
   fetch_unit_if wbus();

   fetch_unit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fetch_unit #(.RESET_PC(8'hFE)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (wbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] word_at(input logic [7:0] a);
      return (hlt_at3 && a == 8'h03) ? 16'hF000 : {8'h00, a};
   endfunction

   // Synchronous instruction memories: data one cycle after the request
   always @(posedge clk) begin
      if (bus.imem_req)  bus.imem_rdata  <= word_at(bus.imem_addr);
      if (wbus.imem_req) wbus.imem_rdata <= word_at(wbus.imem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc);
      exp_q.push_back('{instr: word_at(pc), pc: pc});
   endtask

   task automatic drive(input logic r, input logic s, input logic rd, input logic [7:0] rp);
      @(negedge clk);
      rst             = r;
      bus.stall       = s;
      bus.redirect    = rd;
      bus.redirect_pc = rp;
      #1;
   endtask

   task automatic consume();
      fetch_word_t e;
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0 && bus.redirect === 1'b0) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_extra observed pc=%h expected none", bus.instr_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
            chk("sb_instr", 32'(bus.instr), 32'(e.instr));
         end
      end
   endtask

   task automatic consume_wrap();
      fetch_word_t e;
      if (wbus.instr_valid === 1'b1 && wexp_q.size() != 0) begin
         e = wexp_q.pop_front();
         chk("wrap_pc", 32'(wbus.instr_pc), 32'(e.pc));
      end
   endtask

   task automatic reset_checks();
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_pc", 32'(bus.instr_pc), 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      reset_checks();
      exp_q.delete();
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      hlt_at3         = 1'b0;
      rst             = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      wbus.stall       = 1'b0;
      wbus.redirect    = 1'b0;
      wbus.redirect_pc = '0;

      // Free run, stall, redirect with full buffer, PC wrap
      do_reset();
      chk("wrap_rst_valid", 32'(wbus.instr_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("first_req", 32'(bus.imem_req), 32'd1);
      chk("first_addr", 32'(bus.imem_addr), 32'h00);
      chk("first_valid", 32'(bus.instr_valid), 32'd0);
      chk("wrap_first_addr", 32'(wbus.imem_addr), 32'hFE);
      for (int i = 0; i < 8; i++) push_exp(8'(i));
      wexp_q.push_back('{instr: 16'h00FE, pc: 8'hFE});
      wexp_q.push_back('{instr: 16'h00FF, pc: 8'hFF});
      wexp_q.push_back('{instr: 16'h0000, pc: 8'h00});
      wexp_q.push_back('{instr: 16'h0001, pc: 8'h01});
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("run_valid", 32'(bus.instr_valid), 32'd1);
         consume();
         consume_wrap();
      end
      chk("wrap_all_seen", 32'(wexp_q.size()), 32'd0);

      req_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         chk("stall_hold_pc", 32'(bus.instr_pc), 32'h05);
         chk("stall_hold_valid", 32'(bus.instr_valid), 32'd1);
         if (bus.imem_req === 1'b1) req_cnt++;
      end
      chk("stall_req_le1", 32'(req_cnt <= 1), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("release_valid", 32'(bus.instr_valid), 32'd1);
         consume();
      end
      chk("sb_empty_run", 32'(exp_q.size()), 32'd0);

      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         chk("fill_pc", 32'(bus.instr_pc), 32'h08);
      end
      chk("full_no_req", 32'(bus.imem_req), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 8'h40);
      chk("redir_no_req", 32'(bus.imem_req), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("redir_bubble", 32'(bus.instr_valid), 32'd0);
      chk("redir_req", 32'(bus.imem_req), 32'd1);
      chk("redir_addr", 32'(bus.imem_addr), 32'h40);
      push_exp(8'h40);
      push_exp(8'h41);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("redir_valid", 32'(bus.instr_valid), 32'd1);
         consume();
      end
      chk("sb_empty_redir", 32'(exp_q.size()), 32'd0);

      // HLT word at 03
      hlt_at3 = 1'b1;
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) push_exp(8'(i));
`ifndef FETCH_HALT_EN
      push_exp(8'h04);
      push_exp(8'h05);
`endif
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         consume();
      end
`ifdef FETCH_HALT_EN
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'(i % 2), 1'(i == 3), 8'h20);
         chk("halt_halted", 32'(bus.halted), 32'd1);
         chk("halt_no_valid", 32'(bus.instr_valid), 32'd0);
         chk("halt_no_req", 32'(bus.imem_req), 32'd0);
      end
`else
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("nohalt_halted", 32'(bus.halted), 32'd0);
         consume();
      end
`endif
      chk("sb_empty_hlt", 32'(exp_q.size()), 32'd0);

      // HLT at 03 still buffered when an older redirect arrives
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      push_exp(8'h00);
      push_exp(8'h01);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         consume();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         chk("cancel_hold_pc", 32'(bus.instr_pc), 32'h02);
      end
      drive(1'b0, 1'b1, 1'b1, 8'h10);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("cancel_bubble", 32'(bus.instr_valid), 32'd0);
      chk("cancel_addr", 32'(bus.imem_addr), 32'h10);
      chk("cancel_req", 32'(bus.imem_req), 32'd1);
      push_exp(8'h10);
      push_exp(8'h11);
      push_exp(8'h12);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("cancel_halted", 32'(bus.halted), 32'd0);
         consume();
      end
      chk("sb_empty_cancel", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
